regfile_banked: RTL

//   Parametrised banked register file for the single-cycle datapath, generalising the
//   int/FP register pair to NBANKS banks of DEPTH x WIDTH. Two async read ports (rs, rt),
//   one sync write port. Optional same-cycle write->read bypass. Hardware clear engine

---
 rtl/regfile_banked.sv | 125 ++++++++++++
 1 files changed

// File: rtl/regfile_banked.sv
// Banked register file: NBANKS x DEPTH x WIDTH, two async read ports, one sync write port.
// A clear engine zeroes every row of every bank after reset or on request, holding busy high.
module regfile_banked #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int NBANKS    = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 1,
    localparam int AW = $clog2(DEPTH),
    localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             write_i,
    input  logic             regdst_i,
    input  logic [BW-1:0]    bank_i,
    input  logic [AW-1:0]    rd_i,
    input  logic [AW-1:0]    rs_i,
    input  logic [AW-1:0]    rt_i,
    input  logic [WIDTH-1:0] bus_w_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] bus_a_o,
    output logic [WIDTH-1:0] bus_b_o,
    output logic             busy_o,
    output logic             wr_drop_o
);

    // state   | meaning
    // S_IDLE  | normal operation, writes accepted
    // S_CLEAR | zeroing row cnt_q in all banks each edge; writes dropped
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                wr_drop_q, wr_drop_d;
    logic [WIDTH-1:0]    mem [NBANKS][DEPTH];

    logic                busy;
    logic                clear_start;
    logic                wr_blocked;
    logic                bank_ok;
    logic [BW-1:0]       bank_idx;
    logic [AW-1:0]       wa;
    logic                wr_zero;
    logic                wr_en;
    logic [AW-1:0]       raddr [2];
    logic [WIDTH-1:0]    rdata [2];

    assign busy        = (state_q == S_CLEAR);
    assign clear_start = (state_q == S_IDLE) && clear_i;
    assign wr_blocked  = busy || clear_start;
    assign bank_ok     = ({1'b0, bank_i} < (BW+1)'(NBANKS));
    assign bank_idx    = bank_ok ? bank_i : '0;
    assign wa          = regdst_i ? rd_i : rt_i;
    assign wr_zero     = (ZERO_REG0 != 0) && (bank_i == '0) && (wa == '0);
    // Discarded writes to the zero register or a missing bank are silent (no wr_drop).
    assign wr_en       = write_i && !wr_blocked && bank_ok && !wr_zero;
    assign wr_drop_d   = write_i && wr_blocked;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_CLEAR;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (clear_i) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Storage has no reset; the clear engine is the only way it becomes defined.
    always_ff @(posedge clk_i) begin
        if (busy) begin
            for (int b = 0; b < NBANKS; b++) begin
                mem[b][cnt_q] <= '0;
            end
        end else if (wr_en) begin
            mem[bank_idx][wa] <= bus_w_i;
        end
    end

    assign raddr[0] = rs_i;
    assign raddr[1] = rt_i;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            if (!busy && bank_ok &&
                !((ZERO_REG0 != 0) && (bank_i == '0) && (raddr[p] == '0))) begin
                if ((BYPASS != 0) && wr_en && (raddr[p] == wa)) begin
                    rdata[p] = bus_w_i;
                end else begin
                    rdata[p] = mem[bank_idx][raddr[p]];
                end
            end
        end
    end

    assign bus_a_o   = rdata[0];
    assign bus_b_o   = rdata[1];
    assign busy_o    = busy;
    assign wr_drop_o = wr_drop_q;

endmodule
